// File: rtl/service_window_if.sv
// Dispatcher <-> service window bus: load request toward the window, status back.
interface service_window_if #(
  parameter int NUM_W  = 4,
  parameter int TIME_W = 4,
  parameter int CNT_W  = 8
);
  logic              ld_in;
  logic [NUM_W-1:0]  dn_in;
  logic [TIME_W-1:0] dt_in;
  logic              tick_in;
  logic              busy_out;
  logic [NUM_W-1:0]  cur_num_out;
  logic [TIME_W-1:0] remain_out;
  logic              done_out;
  logic [CNT_W-1:0]  served_cnt_out;
  logic              overrun_out;

  modport master (
    output ld_in, dn_in, dt_in, tick_in,
    input  busy_out, cur_num_out, remain_out, done_out, served_cnt_out, overrun_out
  );
  modport slave (
    input  ld_in, dn_in, dt_in, tick_in,
    output busy_out, cur_num_out, remain_out, done_out, served_cnt_out, overrun_out
  );
endinterface

// File: rtl/service_window.sv
// Single service window: loads a ticket, counts down service ticks, pulses done.
// Optional statistics (served counter, overrun flag) under SERVICE_WINDOW_STATS_EN.
module service_window #(
  parameter int NUM_W  = 4,
  parameter int TIME_W = 4,
  parameter int CNT_W  = 8
) (
  input logic             clk,
  input logic             rst,
  service_window_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE, RELEASE} state_e;

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [NUM_W-1:0]  cur_num_q;
  logic [TIME_W-1:0] remain_q;
  logic [CNT_W-1:0]  served_cnt_q;
  logic              overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cur_num_q    <= '0;
      remain_q     <= '0;
      served_cnt_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ld_in) begin
            state_q   <= SERVE;
            busy_q    <= 1'b1;
            cur_num_q <= bus.dn_in;
            // zero service time still occupies the window for one tick
            remain_q  <= (bus.dt_in == '0) ? TIME_W'(1) : bus.dt_in;
          end
        end
        SERVE: begin
          if (bus.tick_in) begin
            if (remain_q <= TIME_W'(1)) begin
              remain_q <= '0;
              state_q  <= RELEASE;
              done_q   <= 1'b1;
            end else begin
              remain_q <= remain_q - TIME_W'(1);
            end
          end
`ifdef SERVICE_WINDOW_STATS_EN
          if (bus.ld_in) overrun_q <= 1'b1;
`endif
        end
        RELEASE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
`ifdef SERVICE_WINDOW_STATS_EN
          if (served_cnt_q != '1) served_cnt_q <= served_cnt_q + CNT_W'(1);
          if (bus.ld_in) overrun_q <= 1'b1;
`endif
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_out       = busy_q;
  assign bus.done_out       = done_q;
  assign bus.cur_num_out    = cur_num_q;
  assign bus.remain_out     = remain_q;
  assign bus.served_cnt_out = served_cnt_q;
  assign bus.overrun_out    = overrun_q;
endmodule

// File: tb/tb_service_window.sv
// Directed stimulus with a cycle-tagged scoreboard; a negedge monitor compares outputs.
module tb_service_window;
  localparam int NUM_W = 4, TIME_W = 4, CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;

  service_window_if #(.NUM_W(NUM_W), .TIME_W(TIME_W), .CNT_W(CNT_W)) bus ();

  service_window #(.NUM_W(NUM_W), .TIME_W(TIME_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                tag;
    logic              busy;
    logic [NUM_W-1:0]  cur;
    logic [TIME_W-1:0] rem;
    logic              done;
    logic [CNT_W-1:0]  cnt;
    logic              ovr;
    string             nm;
  } exp_t;

  exp_t sb[$];

  // expected statistics, tracked by the stimulus side
  int   exp_cnt = 0;
  logic exp_ovr = 1'b0;

  // one clock of stimulus plus the outputs expected right after that edge
  task automatic step(input logic r, input logic ld, input int dn, input int dt,
                      input logic tk, input logic ignored,
                      input logic eb, input int ecur, input int erem, input logic edone,
                      input string nm);
    exp_t e;
    @(posedge clk); #1;
    rst        = r;
    bus.ld_in  = ld;
    bus.dn_in  = NUM_W'(dn);
    bus.dt_in  = TIME_W'(dt);
    bus.tick_in = tk;
`ifdef SERVICE_WINDOW_STATS_EN
    if (r) begin
      exp_cnt = 0;
      exp_ovr = 1'b0;
    end else if (ignored) begin
      exp_ovr = 1'b1;
    end
`endif
    e.tag  = cyc + 1;
    e.busy = eb;
    e.cur  = NUM_W'(ecur);
    e.rem  = TIME_W'(erem);
    e.done = edone;
    e.cnt  = CNT_W'(exp_cnt);
    e.ovr  = exp_ovr;
    e.nm   = nm;
    sb.push_back(e);
`ifdef SERVICE_WINDOW_STATS_EN
    // counter advances on the edge that leaves RELEASE
    if (edone && !r && exp_cnt < 255) exp_cnt = exp_cnt + 1;
`endif
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].tag <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_total = n_total + 1;
      if (e.tag == cyc &&
          bus.busy_out == e.busy && bus.cur_num_out == e.cur &&
          bus.remain_out == e.rem && bus.done_out == e.done &&
          bus.served_cnt_out == e.cnt && bus.overrun_out == e.ovr) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL %s cyc=%0d: got busy=%b cur=%0d rem=%0d done=%b cnt=%0d ovr=%b, want busy=%b cur=%0d rem=%0d done=%b cnt=%0d ovr=%b (tag %0d)",
                 e.nm, cyc, bus.busy_out, bus.cur_num_out, bus.remain_out, bus.done_out,
                 bus.served_cnt_out, bus.overrun_out,
                 e.busy, e.cur, e.rem, e.done, e.cnt, e.ovr, e.tag);
      end
    end
  end

  initial begin
    bus.ld_in = 1'b0; bus.dn_in = '0; bus.dt_in = '0; bus.tick_in = 1'b0;

    // reset, with a load strobe that must be discarded
    step(1, 1, 9, 5, 1, 0,  0, 0, 0, 0, "rst_ld");
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, "rst_hold");
    step(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, "idle_tick");

    // dn=5 dt=3, tick every cycle; load-cycle tick ignored
    step(0, 1, 5, 3, 1, 0,  1, 5, 3, 0, "a_load");
    step(0, 0, 0, 0, 1, 0,  1, 5, 2, 0, "a_rem2");
    step(0, 0, 0, 0, 1, 0,  1, 5, 1, 0, "a_rem1");
    step(0, 0, 0, 0, 1, 0,  1, 5, 0, 1, "a_done");
    step(0, 0, 0, 0, 1, 0,  0, 5, 0, 0, "a_free");
    step(0, 0, 0, 0, 1, 0,  0, 5, 0, 0, "a_idle_hold");

    // dt=0 serves as one tick
    step(0, 1, 3, 0, 0, 0,  1, 3, 1, 0, "z_load");
    step(0, 0, 0, 0, 0, 0,  1, 3, 1, 0, "z_hold");
    step(0, 0, 0, 0, 1, 0,  1, 3, 0, 1, "z_done");
    step(0, 0, 0, 0, 0, 0,  0, 3, 0, 0, "z_free");

    // load and tick together with dt=2: two further ticks
    step(0, 1, 4, 2, 1, 0,  1, 4, 2, 0, "c_load");
    step(0, 0, 0, 0, 1, 0,  1, 4, 1, 0, "c_rem1");
    step(0, 0, 0, 0, 1, 0,  1, 4, 0, 1, "c_done");
    step(0, 0, 0, 0, 0, 0,  0, 4, 0, 0, "c_free");

    // load dn=7 while serving dn=2 (SERVE and RELEASE)
    step(0, 1, 2, 3, 0, 0,  1, 2, 3, 0, "o_load");
    step(0, 1, 7, 9, 0, 1,  1, 2, 3, 0, "o_ign_serve");
    step(0, 1, 7, 9, 1, 1,  1, 2, 2, 0, "o_ign_tick");
    step(0, 0, 0, 0, 1, 0,  1, 2, 1, 0, "o_rem1");
    step(0, 0, 0, 0, 1, 0,  1, 2, 0, 1, "o_done");
    step(0, 1, 7, 9, 0, 1,  0, 2, 0, 0, "o_ign_release");
    step(0, 0, 0, 0, 0, 0,  0, 2, 0, 0, "o_idle");

    // reset mid-service with remain=4
    step(0, 1, 6, 4, 0, 0,  1, 6, 4, 0, "r_load");
    step(1, 0, 0, 0, 1, 0,  0, 0, 0, 0, "r_rst");
    step(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, "r_no_done");

    // 260 back-to-back single-tick services; counter saturates at 255
    for (int i = 0; i < 260; i++) begin
      step(0, 1, i % 16, 1, 0, 0,  1, i % 16, 1, 0, "s_load");
      step(0, 0, 0, 0, 1, 0,  1, i % 16, 0, 1, "s_done");
      step(0, 0, 0, 0, 0, 0,  0, i % 16, 0, 0, "s_free");
    end
    step(0, 0, 0, 0, 1, 0,  0, 3, 0, 0, "s_final");

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk); #1;
    if (sb.size() > 0) begin
      n_total = n_total + 1;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
